// File: rtl/regfile_multiport_pkg.sv
// regfile_multiport_pkg: shared widths, word/tag types and clear-FSM states for the register file
// Exports: XLEN_DEF, NUM_REGS_DEF, word_t, tag_t, rf_state_t
package regfile_multiport_pkg;
    localparam int XLEN_DEF     = 32;
    localparam int NUM_REGS_DEF = 32;
    typedef logic [XLEN_DEF-1:0]              word_t;
    typedef logic [$clog2(NUM_REGS_DEF)-1:0]  tag_t;
    typedef enum logic {RF_CLEAR, RF_READY}   rf_state_t;
endpackage

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: resolves all write ports plus the clear override into per-entry write enable/data
// Ports:
//   clr      in   clear sequence active; overrides every write port
//   clr_idx  in   entry being cleared this cycle
//   wr_en    in   per-port write enables
//   wr_addr  in   per-port write addresses
//   wr_data  in   per-port write data
//   ent_we   out  per-entry write enable
//   ent_wd   out  per-entry write data
module rf_write_arbiter import regfile_multiport_pkg::*; #(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                clr,
    input  logic [AW-1:0]       clr_idx,
    input  logic [NUM_WR-1:0]   wr_en,
    input  logic [AW-1:0]       wr_addr [NUM_WR],
    input  logic [XLEN-1:0]     wr_data [NUM_WR],
    output logic [NUM_REGS-1:0] ent_we,
    output logic [XLEN-1:0]     ent_wd  [NUM_REGS]
);
    // Ascending port scan so the highest matching index overwrites earlier ones.
    // Addresses at or beyond NUM_REGS match no entry and are dropped.
    always_comb begin
        for (int e = 0; e < NUM_REGS; e++) begin
            ent_we[e] = 1'b0;
            ent_wd[e] = '0;
            if (clr)
                ent_we[e] = 32'(clr_idx) == e;
            else if (!(ZERO_REG != 0 && e == 0))
                for (int j = 0; j < NUM_WR; j++)
                    if (wr_en[j] && 32'(wr_addr[j]) == e) begin
                        ent_we[e] = 1'b1;
                        ent_wd[e] = wr_data[j];
                    end
        end
    end
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: N-read/M-write register file with optional bypass and a post-reset clear sequencer
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset; restarts the clear sequence
//   rd_addr  in   NUM_RD read addresses
//   rd_data  out  NUM_RD registered read data, 1-cycle latency, 0 while clearing
//   wr_en    in   NUM_WR write enables
//   wr_addr  in   NUM_WR write addresses
//   wr_data  in   NUM_WR write data
//   ready    out  high once every entry has been zeroed
module regfile_multiport import regfile_multiport_pkg::*; #(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AW-1:0]     rd_addr [NUM_RD],
    output logic [XLEN-1:0]   rd_data [NUM_RD],
    input  logic [NUM_WR-1:0] wr_en,
    input  logic [AW-1:0]     wr_addr [NUM_WR],
    input  logic [XLEN-1:0]   wr_data [NUM_WR],
    output logic              ready
);
    rf_state_t             state_q, state_d;
    logic [AW-1:0]         clr_idx_q, clr_idx_d;
    logic                  ready_q, ready_d;
    logic                  clear;
    logic [XLEN-1:0]       regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   ent_we;
    logic [XLEN-1:0]       ent_wd [NUM_REGS];

    assign clear = state_q == RF_CLEAR;
    assign ready = ready_q;

    rf_write_arbiter #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG), .AW(AW)
    ) u_arb (
        .clr(clear), .clr_idx(clr_idx_q), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .ent_we(ent_we), .ent_wd(ent_wd)
    );

    always_comb begin
        state_d   = (clear && 32'(clr_idx_q) == NUM_REGS - 1) ? RF_READY : state_q;
        clr_idx_d = clear ? clr_idx_q + 1'b1 : clr_idx_q;
        ready_d   = state_d == RF_READY;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    // No reset term: the clear sequencer is the only initialisation path.
    always_ff @(posedge clock) begin
        for (int e = 0; e < NUM_REGS; e++)
            if (ent_we[e])
                regs_q[e] <= ent_wd[e];
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic            hit;
        logic [XLEN-1:0] rd_data_d, rd_data_q;
        // The arbiter's per-entry result already encodes priority and x0 dropping, so it doubles as the bypass source.
        always_comb begin
            hit       = 32'(rd_addr[i]) < NUM_REGS && !(ZERO_REG != 0 && rd_addr[i] == '0);
            rd_data_d = (clear || !hit) ? '0 :
                        (BYPASS != 0 && ent_we[rd_addr[i]]) ? ent_wd[rd_addr[i]] : regs_q[rd_addr[i]];
        end
        always_ff @(posedge clock) begin
            if (reset)
                rd_data_q <= '0;
            else
                rd_data_q <= rd_data_d;
        end
        assign rd_data[i] = rd_data_q;
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: checks bypass and non-bypass register files against a behavioural model plus directed literals
module tb_regfile_multiport;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rd_addr [2];
    logic [31:0] rd_data_b [2];
    logic [31:0] rd_data_n [2];
    logic [1:0]  wr_en;
    logic [4:0]  wr_addr [2];
    logic [31:0] wr_data [2];
    logic        ready_b, ready_n;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_multiport #(.NUM_WR(2), .BYPASS(1)) dut (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready_b)
    );

    regfile_multiport #(.NUM_WR(2), .BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a counter of edges since reset stands in for the clear sequence; afterwards plain array semantics.
    logic [31:0] mem [32];
    logic [31:0] exp_b [2];
    logic [31:0] exp_n [2];
    logic        exp_rdy;
    int          cnt;
    int          a;
    bit          on = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            on = 1'b1;
            cnt = 0;
            exp_rdy = 1'b0;
            for (int i = 0; i < 2; i++) begin exp_b[i] = 0; exp_n[i] = 0; end
        end else if (on && cnt < 32) begin
            mem[cnt] = 0;
            cnt++;
            for (int i = 0; i < 2; i++) begin exp_b[i] = 0; exp_n[i] = 0; end
            exp_rdy = cnt == 32;
        end else if (on) begin
            for (int i = 0; i < 2; i++) begin
                a = int'(rd_addr[i]);
                exp_n[i] = (a == 0) ? 32'h0 : mem[a];
                exp_b[i] = exp_n[i];
                for (int j = 0; j < 2; j++)
                    if (wr_en[j] && int'(wr_addr[j]) == a && a != 0) exp_b[i] = wr_data[j];
            end
            for (int j = 0; j < 2; j++)
                if (wr_en[j] && wr_addr[j] != 0) mem[wr_addr[j]] = wr_data[j];
            exp_rdy = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (on) begin
            chk("m_rd0_byp", rd_data_b[0], exp_b[0]);
            chk("m_rd1_byp", rd_data_b[1], exp_b[1]);
            chk("m_rd0_nb",  rd_data_n[0], exp_n[0]);
            chk("m_rd1_nb",  rd_data_n[1], exp_n[1]);
            chk("m_ready_byp", 32'(ready_b), 32'(exp_rdy));
            chk("m_ready_nb",  32'(ready_n), 32'(exp_rdy));
        end
    end

    task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
        wr_en = en; wr_addr[0] = a0; wr_data[0] = d0; wr_addr[1] = a1; wr_data[1] = d1;
    endtask

    task automatic clear_window(input string tag);
        chk({tag, "_ready_c1"}, 32'(ready_b), 32'h0);
        for (int k = 2; k <= 32; k++) begin
            @(negedge clock);
            chk({tag, "_ready_clr"}, 32'(ready_b), 32'h0);
            chk({tag, "_rd_clr"}, rd_data_b[0], 32'h0);
        end
        @(negedge clock);
        chk({tag, "_ready_c33"}, 32'(ready_b), 32'h1);
    endtask

    initial begin
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(ready_b), 32'h0);
        chk("rst_rd0", rd_data_b[0], 32'h0);
        reset = 1'b0; rd_addr[0] = 5'd5; rd_addr[1] = 5'd31;
        clear_window("t1");
        // single write then dual-port read
        wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0); rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
        @(negedge clock);
        wr_en = 2'b00; rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
        @(negedge clock);
        chk("t2_rd0", rd_data_b[0], 32'hDEADBEEF);
        chk("t2_rd1", rd_data_b[1], 32'hDEADBEEF);
        // bypass versus pre-write value
        wr(2'b01, 5'd7, 32'h55, 5'd0, 32'h0);
        @(negedge clock);
        wr(2'b01, 5'd7, 32'h1234, 5'd0, 32'h0); rd_addr[0] = 5'd7; rd_addr[1] = 5'd7;
        @(negedge clock);
        chk("t3_byp", rd_data_b[0], 32'h1234);
        chk("t3_nb", rd_data_n[0], 32'h55);
        wr_en = 2'b00;
        @(negedge clock);
        chk("t3_nb_after", rd_data_n[1], 32'h1234);
        // same-address dual write: highest port wins
        wr(2'b11, 5'd9, 32'hAAAA, 5'd9, 32'hBBBB); rd_addr[0] = 5'd9;
        @(negedge clock);
        chk("t4_byp", rd_data_b[0], 32'hBBBB);
        wr_en = 2'b00;
        @(negedge clock);
        chk("t4_rd_byp", rd_data_b[0], 32'hBBBB);
        chk("t4_rd_nb", rd_data_n[0], 32'hBBBB);
        // x0 is hard-wired zero
        wr(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0); rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
        @(negedge clock);
        chk("t5_byp", rd_data_b[0], 32'h0);
        wr_en = 2'b00;
        @(negedge clock);
        chk("t5_rd_byp", rd_data_b[0], 32'h0);
        chk("t5_rd_nb", rd_data_n[0], 32'h0);
        // reset mid-clear and after ready
        wr(2'b01, 5'd3, 32'h77, 5'd0, 32'h0);
        @(negedge clock);
        wr_en = 2'b00; rd_addr[0] = 5'd3;
        @(negedge clock);
        chk("t6_pre", rd_data_b[0], 32'h77);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t6_midclr_ready", 32'(ready_b), 32'h0);
        repeat (40) @(negedge clock);
        chk("t6_ready_up", 32'(ready_b), 32'h1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; rd_addr[0] = 5'd3;
        clear_window("t6");
        @(negedge clock);
        chk("t6_x3_cleared", rd_data_b[0], 32'h0);
        chk("t6_x3_cleared_nb", rd_data_n[0], 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
